// File: rtl/memory_pkg.sv
// Shared types for the memory_bank storage block: FSM states and lane-count helper.
package memory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int lane_count(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/memory_array.sv
// Byte-lane storage core: one write port with lane enables, one registered read port.
module memory_array #(
    parameter int address_width = 4,
    parameter int lanes         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [lanes-1:0]         be,
    input  logic [address_width-1:0] addr,
    input  logic [lanes-1:0][7:0]    wdata,
    output logic [lanes-1:0][7:0]    rdata
);

    localparam int DEPTH = 2 ** address_width;

    // Each lane owns its own byte array so partial writes never touch other lanes.
    for (genvar l = 0; l < lanes; l++) begin : g_lane
        logic [7:0] store [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we && be[l])
                store[addr] <= wdata[l];
        end

        // Read register holds its value until the next read; only reset clears it.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                rd_q <= '0;
            else if (re)
                rd_q <= store[addr];
        end

        assign rdata[l] = rd_q;
    end

endmodule

// File: rtl/memory_bank.sv
// Single-port RAM with valid/ready request port, byte enables, 1-cycle read and
// a hardware clear sweep that zeroes the array after reset or on request.
module memory_bank
    import memory_pkg::*;
#(
    parameter int address_width = 4,
    parameter int data_width    = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                en,
    input  logic [lane_count(data_width)-1:0]   byte_en,
    input  logic [address_width-1:0]           address,
    input  logic [data_width-1:0]              Data_in,
    input  logic                                clear,
    output logic [data_width-1:0]              data_out,
    output logic                                valid_out,
    output logic                                clearing
);

    localparam int LANES = lane_count(data_width);

    if (data_width % 8 != 0) begin : g_bad_width
        $error("memory_bank: data_width must be a multiple of 8");
    end

    state_t                   state;
    logic [address_width-1:0] sweep_cnt;
    logic                     accept;

    logic                     arr_we;
    logic                     arr_re;
    logic [LANES-1:0]         arr_be;
    logic [address_width-1:0] arr_addr;
    logic [data_width-1:0]    arr_wdata;

    // req_ready is only ever high in READY, so accept never collides with the sweep.
    assign accept = req_valid && req_ready;

    always_comb begin
        arr_we    = accept && en;
        arr_re    = accept && !en;
        arr_be    = byte_en;
        arr_addr  = address;
        arr_wdata = Data_in;
        if (state == CLEAR) begin
            arr_we    = 1'b1;
            arr_re    = 1'b0;
            arr_be    = '1;
            arr_addr  = sweep_cnt;
            arr_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            req_ready <= 1'b0;
            clearing  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (&sweep_cnt) begin
                        state     <= READY;
                        req_ready <= 1'b1;
                        clearing  <= 1'b0;
                    end
                end
                READY: begin
                    // A request accepted alongside clear still completes this edge.
                    if (clear) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                        req_ready <= 1'b0;
                        clearing  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            valid_out <= 1'b0;
        else
            valid_out <= arr_re;
    end

    memory_array #(
        .address_width (address_width),
        .lanes         (LANES)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (data_out)
    );

endmodule

// File: doc/memory_bank.md
# memory_bank

Parametrised synchronous single-port RAM with a valid/ready request port, per-byte write enables, registered one-cycle read with a valid pulse, and a hardware clear engine that zeroes the array after reset or on demand. It is the next-generation storage block of the verification-plan designs and sits between a request master (bus adapter or testbench driver) and any consumer of `data_out`. Contents come only from writes and clears; no file preload.

## Interface
- `address_width`, 4: address bits; depth = 2**`address_width`.
- `data_width`, 32: word width; must be a multiple of 8 (elaboration error otherwise).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block accepts a request this cycle.
- `en`  in  1  1 = write, 0 = read; sampled on accept.
- `byte_en`  in  `data_width`/8  write lane enables; ignored on reads.
- `address`  in  `address_width`  request address.
- `Data_in`  in  `data_width`  write data.
- `clear`  in  1  single-cycle request to zero the whole array.
- `data_out`  out  `data_width`  read data.
- `valid_out`  out  1  one-cycle pulse: `data_out` holds a new read result.
- `clearing`  out  1  clear sweep in progress.

## Operation
- Accept = `req_valid` && `req_ready`. Without accept, nothing changes.
- FSM states: CLEAR, READY.
  - Reset (`rst` low) forces CLEAR, sweep counter 0, `req_ready` 0, `valid_out` 0, `data_out` 0, `clearing` 1.
  - CLEAR: each cycle writes all-zero to `mem[counter]`, counter += 1. After writing address depth-1 -> READY. Requests are not accepted.
  - READY: `req_ready` = 1, `clearing` = 0. `clear` high -> CLEAR with counter 0. A request accepted in the same cycle is completed first (its write lands or its read result is produced next cycle).
- Write: for each lane i with `byte_en[i]`=1, `mem[address][8i+7:8i]` <= `Data_in[8i+7:8i]`. Other lanes keep their value. `byte_en` = 0 is a legal no-op write. `valid_out` is not pulsed.
- Read: `data_out` <= `mem[address]`, `valid_out` <= 1 for one cycle. `data_out` holds its value until the next read result; it is not cleared by writes or sweeps.
- Read-after-write: a read accepted the cycle after a write to the same address returns the newly written bytes.
- `clear` during CLEAR is ignored (no restart). `clear` during reset is ignored.
- Reset asserted mid-sweep or mid-read: sweep restarts from 0 after release. A pending `valid_out` is dropped.

## Timing
- Read latency 1: accept at edge N, `data_out`/`valid_out` valid after edge N+1. Back-to-back reads give one result per cycle.
- Write takes effect at the accepting edge.
- Clear latency: exactly 2**`address_width` cycles with `req_ready` low, then `req_ready` high. Default = 16 cycles after the first edge following reset release.
- `req_ready` is a registered function of state only and never depends on `req_valid`.
- No combinational path exists from inputs to outputs.

## Structure
- Package `memory_pkg`: state enum (CLEAR, READY) and the lane-count constant function `data_width`/8.
- Sub-module `memory_array`: byte-enable storage core with one write port and a registered read port. `memory_bank` holds the FSM, sweep counter and handshake, and muxes the clear writes onto the core's write port.

## Test plan
- Reset release -> `req_ready` 0 for 16 cycles, `clearing` 1. Then read every address -> all return 0x00000000 with one `valid_out` pulse each.
- Write 0xDEADBEEF to addr 3 with `byte_en`=4'b1111, then write 0x11223344 to addr 3 with `byte_en`=4'b0101. Read addr 3 -> 0xDE22BE44.
- Write addr 5 = 0xCAFEF00D, then read addr 5 on the next cycle -> 0xCAFEF00D one cycle after accept. Back-to-back reads of addrs 0..15 -> 16 consecutive `valid_out` pulses.
- Fill all addresses, then pulse `clear` together with an accepted write of 0xA5A5A5A5 to addr 15 -> `req_ready` low 16 cycles, then addr 15 reads 0x00000000. With a simultaneous accepted read instead, `valid_out` fires the next cycle with the old value.
- Drive `rst` low at sweep count 7, release it -> full 16-cycle sweep restarts; `valid_out` stays 0 throughout.
- Hold `req_valid` high during CLEAR -> no write occurs. The request is accepted on the first READY cycle.
